lowentropy_prefix_ctrl: RTL and testbench
=========================================

// Module: lowentropy_prefix_ctrl
// PURPOSE
//  Sequencer for the low-entropy variable-to-variable codebooks (codebook_bN family) of the hybrid entropy coder.
//  - Accepts 4-bit input symbols one at a time and grows the active prefix from them.
//  - Drives the active prefix into the combinational codebook and samples its match, length and data results.
//  - Emits one codeword per completed prefix through a valid/ready handshake.
//  - On a flush, emits the flush codeword for a partial prefix.
// PARAMETERS
//  CODEBOOK_LENGTH_MAX  64  active-prefix register width in bits (holds CODEBOOK_LENGTH_MAX/4 symbols)
//  ENCODE_DATALENGTH    21  codeword data width
//  MAX_PREFIX           16  symbol count at which a prefix with no match is an overflow; must be <= CODEBOOK_LENGTH_MAX/4
// PORTS
//  clk_i            in   1   clock; all state on rising edge
//  rst_i            in   1   asynchronous reset, active-high
//  sym_valid_i      in   1   input symbol valid
//  sym_data_i       in   4   input symbol (0x0-0xE; 0xF = escape "X")
//  sym_ready_o      out  1   symbol accepted when valid & ready
//  flush_i          in   1   single-cycle flush request
//  ap_cnt_o         out  6   active prefix symbol count (registered, to codebook ap_cnt_i)
//  ap_data_o        out  CODEBOOK_LENGTH_MAX  active prefix, newest symbol in bits [3:0] (to codebook ap_data_i)
//  encode_match_i   in   1   codebook match
//  encode_length_i  in   6   codebook codeword length
//  encode_data_i    in   ENCODE_DATALENGTH  codebook codeword, right-aligned
//  flush_length_i   in   6   flush-table length for current ap_cnt_o/ap_data_o
//  flush_data_i     in   ENCODE_DATALENGTH  flush-table codeword
//  cw_valid_o       out  1   codeword valid
//  cw_ready_i       in   1   downstream ready
//  cw_length_o      out  6   codeword length
//  cw_data_o        out  ENCODE_DATALENGTH  codeword, right-aligned
//  flush_done_o     out  1   one-cycle pulse when a flush completes
//  err_o            out  1   sticky prefix-overflow flag
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. State is ACCEPT. flush_pend is cleared.
//   - Reset in any state drops the prefix, any pending codeword and any pending flush.
//  States: ACCEPT, LOOKUP, EMIT, FLUSH_EMIT.
//  ACCEPT:
//   - sym_ready_o = !flush_pend.
//   - On a symbol handshake: ap_data_o <= (ap_data_o<<4)|sym_data_i; ap_cnt_o <= ap_cnt_o+1; go to LOOKUP.
//   - If flush_pend and ap_cnt_o==0: clear flush_pend, pulse flush_done_o, stay in ACCEPT.
//   - If flush_pend and ap_cnt_o!=0: latch flush_length_i and flush_data_i into cw_*, go to FLUSH_EMIT.
//  LOOKUP (exactly 1 cycle; sym_ready_o=0):
//   - Sample encode_match_i against the registered prefix.
//   - Match: latch encode_length_i and encode_data_i into cw_*, go to EMIT.
//   - No match and ap_cnt_o==MAX_PREFIX: set err_o, clear the prefix, go to ACCEPT. No codeword is emitted.
//   - Otherwise: go to ACCEPT.
//  EMIT / FLUSH_EMIT:
//   - cw_valid_o=1. cw_* are held stable while cw_ready_i=0.
//   - On cw_ready_i: ap_cnt_o<=0, ap_data_o<=0, go to ACCEPT.
//   - FLUSH_EMIT additionally clears flush_pend and pulses flush_done_o on that edge.
//  Latency: symbol accepted at edge N -> LOOKUP in cycle N+1 -> cw_valid_o asserted at N+2.
//   - Peak throughput is 1 symbol per 2 cycles; 3 cycles when a codeword is produced and ready is held high.
//  Flush capture:
//   - flush_i sets flush_pend in any state.
//   - If flush_i arrives in the same cycle as a symbol handshake, the symbol is taken first; the flush is serviced on return to ACCEPT.
//   - A second flush_i while flush_pend is set is absorbed.
//  Arithmetic: ap_cnt_o never exceeds MAX_PREFIX. The shift discards bits above CODEBOOK_LENGTH_MAX.
//  err_o is cleared only by rst_i.
// CONFIGURATION
//  LE_STATS_EN defined:
//   - Adds outputs cw_count_o[31:0] and bit_count_o[31:0].
//   - Both update on every cw handshake, including flush codewords: cw_count_o += 1, bit_count_o += cw_length_o.
//   - Both wrap modulo 2^32 and reset to 0.
//  LE_STATS_EN not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING (codebook_b7 connected)
//  - sym 0x2, ready=1 -> 1 codeword: length 3, data 'b100; prefix then cleared to 0.
//  - sym 0x0,0x0 -> LOOKUP after sym 1 misses; after sym 2: ap_cnt_o=2, ap_data_o=0x00 -> codeword length 1, data 0.
//  - sym 0x1,0x1,0x1 with cw_ready_i low 5 cycles -> cw_valid_o held; length 8, data 'b11110110 stable until ready.
//  - sym 0x0,0x1 then flush_i, flush table returns len 5 data 0x1B -> that codeword emitted, flush_done_o 1 pulse, prefix 0.
//  - flush_i with empty prefix -> no codeword; flush_done_o pulses 1 cycle later.
//  - stub codebook match=0, MAX_PREFIX=16, 16 symbols -> err_o=1 after 16th LOOKUP, ap_cnt_o=0, no cw_valid_o.

Source files
------------

// File: rtl/lowentropy_prefix_ctrl.sv
// Prefix sequencer for the low-entropy variable-to-variable codebooks.
// Collects 4-bit symbols into an active prefix, asks the external combinational
// codebook for a match one cycle later, and emits one codeword per completed
// prefix over a valid/ready handshake. A flush emits the flush-table codeword
// for whatever partial prefix is pending.
// Optional feature: define LE_STATS_EN to add codeword/bit statistics counters.
module lowentropy_prefix_ctrl #(
  parameter int unsigned CODEBOOK_LENGTH_MAX = 64,
  parameter int unsigned ENCODE_DATALENGTH   = 21,
  parameter int unsigned MAX_PREFIX          = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sym_valid_i,
  input  logic [3:0]                     sym_data_i,
  output logic                           sym_ready_o,
  input  logic                           flush_i,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  input  logic                           encode_match_i,
  input  logic [5:0]                     encode_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   encode_data_i,
  input  logic [5:0]                     flush_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   flush_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           flush_done_o,
  output logic                           err_o
`ifdef LE_STATS_EN
  ,
  output logic [31:0]                    cw_count_o,
  output logic [31:0]                    bit_count_o
`endif
);

  localparam logic [1:0] StAccept    = 2'd0;
  localparam logic [1:0] StLookup    = 2'd1;
  localparam logic [1:0] StEmit      = 2'd2;
  localparam logic [1:0] StFlushEmit = 2'd3;

  localparam logic [5:0] MaxCnt = 6'(MAX_PREFIX);

  logic [1:0]                     state_q, state_d;
  logic [5:0]                     ap_cnt_q, ap_cnt_d;
  logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_q, ap_data_d;
  logic [5:0]                     cw_len_q, cw_len_d;
  logic [ENCODE_DATALENGTH-1:0]   cw_data_q, cw_data_d;
  logic                           flush_pend_q, flush_pend_d;
  logic                           flush_done_q, flush_done_d;
  logic                           err_q, err_d;

  logic sym_hs;
  logic cw_hs;

  // Handshake qualifiers and registered outputs; ready is masked during reset
  // so every output reads 0 while rst_i is held.
  always_comb begin
    sym_ready_o  = (state_q == StAccept) && !flush_pend_q && !rst_i;
    sym_hs       = sym_valid_i && sym_ready_o;
    cw_valid_o   = (state_q == StEmit) || (state_q == StFlushEmit);
    cw_hs        = cw_valid_o && cw_ready_i;
    ap_cnt_o     = ap_cnt_q;
    ap_data_o    = ap_data_q;
    cw_length_o  = cw_len_q;
    cw_data_o    = cw_data_q;
    flush_done_o = flush_done_q;
    err_o        = err_q;
  end

  // Next-state logic for the sequencer, prefix, codeword and flush tracking.
  always_comb begin
    state_d      = state_q;
    ap_cnt_d     = ap_cnt_q;
    ap_data_d    = ap_data_q;
    cw_len_d     = cw_len_q;
    cw_data_d    = cw_data_q;
    // A flush request is remembered in any state; repeats simply re-set it.
    flush_pend_d = flush_pend_q | flush_i;
    flush_done_d = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      StAccept: begin
        if (sym_hs) begin
          // Symbol wins over a same-cycle flush; the flush is served later.
          ap_data_d = {ap_data_q[CODEBOOK_LENGTH_MAX-5:0], sym_data_i};
          ap_cnt_d  = ap_cnt_q + 6'd1;
          state_d   = StLookup;
        end else if (flush_pend_q) begin
          if (ap_cnt_q == 6'd0) begin
            // Nothing buffered: the flush completes without a codeword.
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
          end else begin
            cw_len_d  = flush_length_i;
            cw_data_d = flush_data_i;
            state_d   = StFlushEmit;
          end
        end
      end

      StLookup: begin
        if (encode_match_i) begin
          cw_len_d  = encode_length_i;
          cw_data_d = encode_data_i;
          state_d   = StEmit;
        end else if (ap_cnt_q == MaxCnt) begin
          // Prefix can grow no further without a match: drop it and flag.
          err_d     = 1'b1;
          ap_cnt_d  = 6'd0;
          ap_data_d = '0;
          state_d   = StAccept;
        end else begin
          state_d = StAccept;
        end
      end

      StEmit: begin
        if (cw_ready_i) begin
          ap_cnt_d  = 6'd0;
          ap_data_d = '0;
          state_d   = StAccept;
        end
      end

      StFlushEmit: begin
        if (cw_ready_i) begin
          ap_cnt_d     = 6'd0;
          ap_data_d    = '0;
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
          state_d      = StAccept;
        end
      end

      default: begin
        state_d = StAccept;
      end
    endcase
  end

  // State registers, asynchronously cleared by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StAccept;
      ap_cnt_q     <= 6'd0;
      ap_data_q    <= '0;
      cw_len_q     <= 6'd0;
      cw_data_q    <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ap_cnt_q     <= ap_cnt_d;
      ap_data_q    <= ap_data_d;
      cw_len_q     <= cw_len_d;
      cw_data_q    <= cw_data_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

`ifdef LE_STATS_EN
  logic [31:0] cw_count_q;
  logic [31:0] bit_count_q;

  // Codeword and bit totals, counting flush codewords too; both wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cw_count_q  <= 32'd0;
      bit_count_q <= 32'd0;
    end else if (cw_hs) begin
      cw_count_q  <= cw_count_q + 32'd1;
      bit_count_q <= bit_count_q + 32'(cw_len_q);
    end
  end

  // Expose the statistics counters.
  always_comb begin
    cw_count_o  = cw_count_q;
    bit_count_o = bit_count_q;
  end
`else
  logic unused_cw_hs;

  // Handshake is only consumed by the statistics option.
  always_comb begin
    unused_cw_hs = cw_hs;
  end
`endif

endmodule

// File: tb/tb_lowentropy_prefix_ctrl.sv
// Directed bench for lowentropy_prefix_ctrl with a small codebook_b7 stand-in.
module tb_lowentropy_prefix_ctrl;

  localparam int unsigned CLM = 64;
  localparam int unsigned EDL = 21;

  logic           clk;
  logic           rst;
  logic           sym_valid;
  logic [3:0]     sym_data;
  logic           sym_ready;
  logic           flush;
  logic [5:0]     ap_cnt;
  logic [CLM-1:0] ap_data;
  logic           enc_match;
  logic [5:0]     enc_len;
  logic [EDL-1:0] enc_data;
  logic [5:0]     fl_len;
  logic [EDL-1:0] fl_data;
  logic           cw_valid;
  logic           cw_ready;
  logic [5:0]     cw_len;
  logic [EDL-1:0] cw_data;
  logic           flush_done;
  logic           err;
`ifdef LE_STATS_EN
  logic [31:0]    cw_count;
  logic [31:0]    bit_count;
`endif

  logic stub_miss;
  int   total;
  int   bad;

  lowentropy_prefix_ctrl #(
    .CODEBOOK_LENGTH_MAX (CLM),
    .ENCODE_DATALENGTH   (EDL),
    .MAX_PREFIX          (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sym_valid_i     (sym_valid),
    .sym_data_i      (sym_data),
    .sym_ready_o     (sym_ready),
    .flush_i         (flush),
    .ap_cnt_o        (ap_cnt),
    .ap_data_o       (ap_data),
    .encode_match_i  (enc_match),
    .encode_length_i (enc_len),
    .encode_data_i   (enc_data),
    .flush_length_i  (fl_len),
    .flush_data_i    (fl_data),
    .cw_valid_o      (cw_valid),
    .cw_ready_i      (cw_ready),
    .cw_length_o     (cw_len),
    .cw_data_o       (cw_data),
    .flush_done_o    (flush_done),
    .err_o           (err)
`ifdef LE_STATS_EN
    ,
    .cw_count_o      (cw_count),
    .bit_count_o     (bit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the few codebook_b7 / flush-table entries the steps need.
  always_comb begin
    enc_match = 1'b0;
    enc_len   = 6'd0;
    enc_data  = '0;
    fl_len    = 6'd0;
    fl_data   = '0;
    if (!stub_miss) begin
      if (ap_cnt == 6'd1 && ap_data == 64'h2) begin
        enc_match = 1'b1; enc_len = 6'd3; enc_data = 21'b100;
      end else if (ap_cnt == 6'd2 && ap_data == 64'h00) begin
        enc_match = 1'b1; enc_len = 6'd1; enc_data = 21'd0;
      end else if (ap_cnt == 6'd3 && ap_data == 64'h111) begin
        enc_match = 1'b1; enc_len = 6'd8; enc_data = 21'b11110110;
      end
    end
    if (ap_cnt == 6'd2 && ap_data == 64'h01) begin
      fl_len = 6'd5; fl_data = 21'h1B;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one symbol for a cycle; returns at the negedge inside LOOKUP.
  task automatic send_sym(input logic [3:0] d, input logic with_flush);
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = d;
    flush     = with_flush;
    @(negedge clk);
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; sym_valid = 1'b0; sym_data = 4'h0; flush = 1'b0;
    cw_ready = 1'b1; stub_miss = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(sym_ready), 64'd0);
    check("rst_cnt", 64'(ap_cnt), 64'd0);
    check("rst_outs", 64'({cw_valid, cw_len, cw_data, flush_done, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(sym_ready), 64'd1);

    // Single-symbol codeword "2"
    send_sym(4'h2, 1'b0);
    check("s2_lookup_cnt", 64'(ap_cnt), 64'd1);
    check("s2_lookup_data", ap_data, 64'h2);
    check("s2_lookup_ready", 64'(sym_ready), 64'd0);
    check("s2_lookup_valid", 64'(cw_valid), 64'd0);
    @(negedge clk);
    check("s2_cw", 64'({cw_valid, cw_len, cw_data}), 64'({1'b1, 6'd3, 21'b100}));
    @(negedge clk);
    check("s2_cleared", 64'({cw_valid, ap_cnt}), 64'd0);
    check("s2_data_cleared", ap_data, 64'd0);

    // Two-symbol codeword "00", first lookup misses
    send_sym(4'h0, 1'b0);
    check("s00_first_cnt", 64'(ap_cnt), 64'd1);
    @(negedge clk);
    check("s00_miss_novalid", 64'(cw_valid), 64'd0);
    check("s00_miss_ready", 64'(sym_ready), 64'd1);
    send_sym(4'h0, 1'b0);
    check("s00_second_cnt", 64'(ap_cnt), 64'd2);
    check("s00_second_data", ap_data, 64'h00);
    @(negedge clk);
    check("s00_cw", 64'({cw_valid, cw_len, cw_data}), 64'({1'b1, 6'd1, 21'd0}));
    @(negedge clk);

    // "111" with downstream stalled for 5 cycles
    cw_ready = 1'b0;
    send_sym(4'h1, 1'b0);
    @(negedge clk);
    send_sym(4'h1, 1'b0);
    @(negedge clk);
    send_sym(4'h1, 1'b0);
    check("s111_cnt", 64'(ap_cnt), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s111_hold", 64'({cw_valid, cw_len, cw_data}), 64'({1'b1, 6'd8, 21'b11110110}));
    end
    cw_ready = 1'b1;
    @(negedge clk);
    check("s111_released", 64'({cw_valid, ap_cnt}), 64'd0);

    // "01" then flush: flush-table codeword emitted
    send_sym(4'h0, 1'b0);
    @(negedge clk);
    send_sym(4'h1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_pend_ready", 64'(sym_ready), 64'd0);
    check("fl_pend_novalid", 64'(cw_valid), 64'd0);
    @(negedge clk);
    check("fl_cw", 64'({cw_valid, cw_len, cw_data}), 64'({1'b1, 6'd5, 21'h1B}));
    check("fl_not_done_yet", 64'(flush_done), 64'd0);
    @(negedge clk);
    check("fl_done", 64'({flush_done, cw_valid, ap_cnt}), 64'({1'b1, 1'b0, 6'd0}));
    @(negedge clk);
    check("fl_done_pulse", 64'({flush_done, sym_ready}), 64'({1'b0, 1'b1}));

    // Flush with an empty prefix
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fe_pend", 64'({flush_done, sym_ready, cw_valid}), 64'd0);
    @(negedge clk);
    check("fe_done", 64'({flush_done, cw_valid}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("fe_done_pulse", 64'({flush_done, sym_ready}), 64'({1'b0, 1'b1}));

    // Flush in the same cycle as a symbol: symbol served first
    send_sym(4'h2, 1'b1);
    check("fs_lookup_cnt", 64'(ap_cnt), 64'd1);
    @(negedge clk);
    check("fs_cw", 64'({cw_valid, cw_len, cw_data}), 64'({1'b1, 6'd3, 21'b100}));
    @(negedge clk);
    check("fs_pend", 64'({sym_ready, flush_done, cw_valid}), 64'd0);
    @(negedge clk);
    check("fs_done", 64'({flush_done, cw_valid}), 64'({1'b1, 1'b0}));

    // Overflow: 16 unmatched symbols
    stub_miss = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_sym(4'(i % 15), 1'b0);
      check("ov_novalid", 64'({cw_valid, err}), 64'd0);
      @(negedge clk);
    end
    check("ov_err", 64'({err, cw_valid, ap_cnt}), 64'({1'b1, 1'b0, 6'd0}));
    check("ov_data", ap_data, 64'd0);

    // Sticky error while normal coding continues
    stub_miss = 1'b0;
    send_sym(4'h2, 1'b0);
    @(negedge clk);
    check("sticky_cw", 64'({err, cw_valid, cw_len}), 64'({1'b1, 1'b1, 6'd3}));
    @(negedge clk);
    check("sticky_err", 64'(err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
